sram_bus_bridge: RTL and testbench
==================================

Name: sram_bus_bridge

Overview:
Valid/ready request/response bridge between the RISC-V core's data-memory port and the 4 KB SRAM wrapper (1024 x 32, 1-cycle read latency, byte enables).
- Translates byte addresses to word addresses and drives the wrapper's cs/we/be/addr/din.
- Captures read data one cycle after issue.
- Returns exactly one in-order response per accepted request, buffered so the core can back-pressure.

Parameters:
BASE_ADDR, 32'h0000_0000, byte base address of the SRAM window
DEPTH_WORDS, 1024, SRAM depth in 32-bit words; SRAM address width = clog2(DEPTH_WORDS)
RSP_DEPTH, 2, response buffer entries (>=2 required for full throughput)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous, active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_we  in  1  1=write, 0=read
req_addr  in  32  byte address
req_wdata  in  32  write data
req_wstrb  in  4  byte strobes
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when valid&ready
rsp_rdata  out  32  read data (0 for writes)
rsp_err  out  1  error flag (tied 0 unless SRAM_BRIDGE_ERR_EN)
sram_cs  out  1  to wrapper cs
sram_we  out  1  to wrapper we
sram_be  out  4  to wrapper be
sram_addr  out  10  to wrapper addr (clog2(DEPTH_WORDS))
sram_din  out  32  to wrapper din
sram_dout  in  32  from wrapper dout, valid cycle after read issue

Behaviour:
- Reset: synchronous; clears response buffer, in-flight flag and counters. In-flight or buffered responses are discarded. rsp_valid=0, rsp_err=0, rsp_rdata=0 during and after reset. req_ready=0 while rst_n=0.
- Occupancy = buffered entries + in-flight (0/1).
- req_ready = (occupancy < RSP_DEPTH) | (rsp_valid & rsp_ready). The pop-aware path is combinational from rsp_ready.
- Issue: on accept in cycle N, sram_cs=1 combinationally in cycle N.
  - sram_we=req_we; sram_be=req_we ? req_wstrb : 4'h0.
  - sram_addr=(req_addr-BASE_ADDR)[11:2]; sram_din=req_wdata.
  - sram_cs=0 in every cycle without an accept.
- Capture: in-flight flag set at N; at N+1, read data from sram_dout (writes: 0) is pushed into the buffer.
- Response: rsp_valid earliest at N+2; strictly in request order.
- Throughput: with RSP_DEPTH=2 and rsp_ready=1, one request per cycle sustained.
- Back-pressure: when rsp_ready=0, the buffer fills and req_ready drops once occupancy=RSP_DEPTH. The in-flight slot is always reserved, so no overflow.
- Simultaneous push and pop: count unchanged; no bubble.
- Write with wstrb=0: still issued (cs=1, be=0 no-op) and acknowledged.
- Address handling without the feature: req_addr[1:0] ignored; offsets wrap modulo DEPTH_WORDS*4.

Optional Feature:
SRAM_BRIDGE_ERR_EN:
- Defined: a request is flagged if req_addr[1:0]!=0 or (req_addr-BASE_ADDR) >= DEPTH_WORDS*4.
  - It is accepted, but sram_cs stays 0.
  - It receives a normal-latency in-order response with rsp_err=1 and rsp_rdata=0.
  - The error bit is stored per buffer entry.
- Undefined: rsp_err tied 0; no range or alignment check; wrap as above.

Decomposition:
- Package riscv_mem_pkg holds:
  - SRAM_DEPTH_WORDS=1024, SRAM_AW=10, SRAM_BASE=32'h0
  - response entry layout {err, rdata[31:0]}
- Sub-module sram_rsp_fifo: synchronous FIFO, parameter DEPTH, width 33, with push/pop/count/full/empty. Simultaneous push and pop are legal when full.

Test Plan:
- Reset: hold rst_n=0 with req_valid=1 -> sram_cs=0, rsp_valid=0, req_ready=0. Release -> req_ready=1 next cycle.
- Write then read: write 0xDEADBEEF @0x10, wstrb=F; read @0x10 -> sram_addr=4 both times; write rsp rdata=0; read rsp rdata=0xDEADBEEF at accept+2.
- Byte write: wstrb=4'b0100, wdata=0x00AA0000 @0x10, then read -> sram_be=0100; read returns 0xDEAABEEF.
- Streaming: 8 back-to-back reads @0x0..0x1C, rsp_ready=1 -> req_ready stays 1; 8 in-order responses on consecutive cycles.
- Back-pressure: rsp_ready=0 for 5 cycles with req_valid=1 -> exactly 2 accepts, then req_ready=0. Release -> responses drain in order, with no loss or duplicates.
- Reset mid-stream (read in flight plus one buffered) -> both discarded; no rsp_valid after reset. With SRAM_BRIDGE_ERR_EN: read @0x1002 and @0x1000 -> sram_cs=0, rsp_err=1, rdata=0.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: SRAM geometry shared by the data-memory path, plus the layout of one response entry {err, rdata}
package riscv_mem_pkg;
  localparam int SRAM_DEPTH_WORDS = 1024;
  localparam int SRAM_AW = 10;
  localparam logic [31:0] SRAM_BASE = 32'h0;
  typedef struct packed {
    logic err;
    logic [31:0] rdata;
  } rsp_entry_t;
endpackage

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo: synchronous FIFO holding bridge responses; push and pop may happen together even when full
// Ports: clk, rst_n (sync, active-low), push/din in, pop in, dout = head entry, count/full/empty status
module sram_rsp_fifo
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W = $bits(rsp_entry_t),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    wr_d = push ? inc(wr_q) : wr_q;
    rd_d = pop ? inc(rd_q) : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) if (push) mem_q[wr_q] <= din;
  assign dout = mem_q[rd_q];
  assign count = cnt_q;
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
endmodule

// File: rtl/sram_bus_bridge.sv
// sram_bus_bridge: valid/ready bridge from the core data port to a 1-cycle-latency SRAM wrapper, in-order buffered responses
// Ports: clk, rst_n (sync, active-low); req_* request channel in; rsp_* response channel out;
//        sram_cs/we/be/addr/din to the wrapper, sram_dout back from it one cycle after a read.
// Optional: define SRAM_BRIDGE_ERR_EN to flag misaligned or out-of-window requests (no SRAM access, rsp_err=1).
module sram_bus_bridge
  import riscv_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = SRAM_BASE,
  parameter int DEPTH_WORDS = SRAM_DEPTH_WORDS,
  parameter int RSP_DEPTH = 2,
  localparam int AW = $clog2(DEPTH_WORDS),
  localparam int CW = $clog2(RSP_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  input  logic [3:0]    req_wstrb,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          sram_cs,
  output logic          sram_we,
  output logic [3:0]    sram_be,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_din,
  input  logic [31:0]   sram_dout
);
  logic [31:0] off;
  logic bad, accept, pop;
  logic infl_q, infl_d, infl_rd_q, infl_rd_d, infl_err_q, infl_err_d;
  logic [CW-1:0] count;
  logic empty;
  rsp_entry_t push_e, head;
  assign off = req_addr - BASE_ADDR;
`ifdef SRAM_BRIDGE_ERR_EN
  assign bad = |req_addr[1:0] | (off >= 32'(DEPTH_WORDS * 4));
`else
  assign bad = 1'b0;
`endif
  assign rsp_valid = rst_n & ~empty;
  assign pop = rsp_valid & rsp_ready;
  // the in-flight slot counts as occupied so its capture can never overflow the buffer
  assign req_ready = rst_n & ((({1'b0, count} + (CW + 1)'(infl_q)) < (CW + 1)'(RSP_DEPTH)) | pop);
  assign accept = req_valid & req_ready;
  assign sram_cs = accept & ~bad;
  assign sram_we = req_we;
  assign sram_be = req_we ? req_wstrb : 4'h0;
  assign sram_addr = off[AW+1:2];
  assign sram_din = req_wdata;
  always_comb begin
    infl_d = accept;
    infl_rd_d = accept & ~req_we & ~bad;
    infl_err_d = accept & bad;
    push_e.err = infl_err_q;
    push_e.rdata = infl_rd_q ? sram_dout : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      infl_q <= 1'b0;
      infl_rd_q <= 1'b0;
      infl_err_q <= 1'b0;
    end else begin
      infl_q <= infl_d;
      infl_rd_q <= infl_rd_d;
      infl_err_q <= infl_err_d;
    end
  end
  sram_rsp_fifo #(.DEPTH(RSP_DEPTH), .W($bits(rsp_entry_t))) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(infl_q),
    .din(push_e),
    .pop(pop),
    .dout(head),
    .count(count),
    .full(),
    .empty(empty)
  );
  assign rsp_rdata = rsp_valid ? head.rdata : '0;
  assign rsp_err = rsp_valid & head.err;
endmodule

// File: tb/tb_sram_bus_bridge.sv
// tb_sram_bus_bridge: scoreboard bench for sram_bus_bridge with a behavioural 1024x32 SRAM wrapper model
module tb_sram_bus_bridge;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0] req_wstrb = '0;
  logic req_ready, rsp_valid, rsp_err, sram_cs, sram_we;
  logic [31:0] rsp_rdata, sram_din, sram_dout;
  logic [3:0] sram_be;
  logic [9:0] sram_addr;
  logic [31:0] mem [1024];
  int n_chk = 0, n_fail = 0, cyc = 0;
  typedef struct {
    logic [32:0] v;
    int c;
    bit lat;
  } exp_t;
  exp_t sb[$];
  exp_t me;
  sram_bus_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_be(sram_be), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++) if (sram_be[b]) mem[sram_addr][8*b+:8] <= sram_din[8*b+:8];
      end else sram_dout <= mem[sram_addr];
    end
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic push_exp(input logic [32:0] v, input bit lat);
    exp_t e;
    e.v = v;
    e.c = cyc;
    e.lat = lat;
    sb.push_back(e);
  endtask
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rsp_unexpected: got err=%b rdata=%h with no outstanding request", rsp_err, rsp_rdata);
      end else begin
        me = sb.pop_front();
        chk("rsp", 64'({rsp_err, rsp_rdata}), 64'(me.v));
        if (me.lat) chk("rsp_latency", 64'(cyc), 64'(me.c + 2));
      end
    end
  end
  task automatic send(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                      input logic ecs, input logic [9:0] ea, input logic [3:0] ebe,
                      input logic [32:0] ev, input bit lat, output int waits);
    req_valid = 1'b1;
    req_we = we;
    req_addr = a;
    req_wdata = wd;
    req_wstrb = st;
    waits = 0;
    @(negedge clk);
    while (!req_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!req_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: request @%h never accepted", a);
    end else begin
      chk("sram_cs", 64'(sram_cs), 64'(ecs));
      if (ecs) begin
        chk("sram_addr", 64'(sram_addr), 64'(ea));
        chk("sram_we", 64'(sram_we), 64'(we));
        chk("sram_be", 64'(sram_be), 64'(ebe));
        if (we) chk("sram_din", 64'(sram_din), 64'(wd));
      end
      push_exp(ev, lat);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask
  task automatic drain();
    for (int t = 0; t < 40 && sb.size() != 0; t++) @(negedge clk);
    chk("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    int w, acc;
    bit last_rdy;
    rst_n = 1'b0;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_cs", 64'(sram_cs), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    chk("reset_rdata", 64'(rsp_rdata), 64'd0);
    chk("reset_err", 64'(rsp_err), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 10'd4, 4'hF, 33'h0, 1'b1, w);
    send(1'b0, 32'h10, 32'h0, 4'hF, 1'b1, 10'd4, 4'h0, {1'b0, 32'hDEADBEEF}, 1'b1, w);
    send(1'b1, 32'h10, 32'h00AA0000, 4'b0100, 1'b1, 10'd4, 4'b0100, 33'h0, 1'b1, w);
    send(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 10'd4, 4'h0, {1'b0, 32'hDEAABEEF}, 1'b1, w);
    drain();
    for (int i = 0; i < 8; i++)
      send(1'b1, 32'(i * 4), 32'hA0000000 + 32'(i), 4'hF, 1'b1, 10'(i), 4'hF, 33'h0, 1'b1, w);
    for (int i = 0; i < 8; i++) begin
      send(1'b0, 32'(i * 4), 32'h0, 4'h0, 1'b1, 10'(i), 4'h0, {1'b0, 32'hA0000000 + 32'(i)}, 1'b1, w);
      chk("stream_ready", 64'(w), 64'd0);
    end
    drain();
    send(1'b1, 32'h4, 32'hFFFFFFFF, 4'h0, 1'b1, 10'd1, 4'h0, 33'h0, 1'b1, w);
    send(1'b0, 32'h4, 32'h0, 4'h0, 1'b1, 10'd1, 4'h0, {1'b0, 32'hA0000001}, 1'b1, w);
`ifndef SRAM_BRIDGE_ERR_EN
    send(1'b0, 32'h1010, 32'h0, 4'h0, 1'b1, 10'd4, 4'h0, {1'b0, 32'hA0000004}, 1'b1, w);
    send(1'b0, 32'h13, 32'h0, 4'h0, 1'b1, 10'd4, 4'h0, {1'b0, 32'hA0000004}, 1'b1, w);
`else
    send(1'b0, 32'h1002, 32'h0, 4'h0, 1'b0, 10'd0, 4'h0, {1'b1, 32'h0}, 1'b1, w);
    send(1'b0, 32'h1000, 32'h0, 4'h0, 1'b0, 10'd0, 4'h0, {1'b1, 32'h0}, 1'b1, w);
    send(1'b0, 32'h13, 32'h0, 4'h0, 1'b0, 10'd0, 4'h0, {1'b1, 32'h0}, 1'b1, w);
    send(1'b0, 32'h14, 32'h0, 4'h0, 1'b1, 10'd5, 4'h0, {1'b0, 32'hA0000005}, 1'b1, w);
`endif
    drain();
    rsp_ready = 1'b0;
    req_we = 1'b0;
    req_wstrb = 4'h0;
    acc = 0;
    last_rdy = 1'b1;
    repeat (5) begin
      req_valid = 1'b1;
      req_addr = 32'(acc * 4);
      @(negedge clk);
      last_rdy = req_ready;
      if (req_ready) begin
        chk("bp_cs", 64'(sram_cs), 64'd1);
        push_exp({1'b0, 32'hA0000000 + 32'(acc)}, 1'b0);
        acc++;
      end
      @(posedge clk);
      #1;
    end
    chk("bp_accepts", 64'(acc), 64'd2);
    chk("bp_full_ready", 64'(last_rdy), 64'd0);
    rsp_ready = 1'b1;
    req_addr = 32'h8;
    @(negedge clk);
    chk("pop_aware_ready", 64'(req_ready), 64'd1);
    if (req_ready) push_exp({1'b0, 32'hA0000002}, 1'b0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    drain();
    rsp_ready = 1'b0;
    send(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 10'd0, 4'h0, {1'b0, 32'hA0000000}, 1'b0, w);
    send(1'b0, 32'h4, 32'h0, 4'h0, 1'b1, 10'd1, 4'h0, {1'b0, 32'hA0000001}, 1'b0, w);
    @(negedge clk);
    chk("mid_rsp_valid", 64'(rsp_valid), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    rsp_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("mid_reset_rsp_valid", 64'(rsp_valid), 64'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_reset_no_rsp", 64'(rsp_valid), 64'd0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
